// File: rtl/shared_net_arbiter.sv
// Round-robin owner arbiter for a shared wired/tri-state net: one-hot driver enables,
// a fixed no-driver turnaround between owners, and a beat-count ownership timeout.
module shared_net_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 8,
  parameter int TURN_CYC  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_last,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_owner_id,
  output logic                 o_owner_vld,
  output logic [7:0]           o_beat_cnt,
  output logic                 o_timeout
);

  localparam int               IDW       = $clog2(N);
  localparam logic [7:0]       BEAT_MAX  = 8'(MAX_BEATS - 1);
  localparam logic [2:0]       TURN_LAST = 3'(TURN_CYC - 1);
  localparam logic [IDW-1:0]   ID_LAST   = IDW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  // {found, index} of the first requester at or above ptr, wrapping modulo N
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] req, input logic [IDW-1:0] ptr);
    logic [IDW:0] res;
    int           idx;
    res = {(IDW+1){1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      res = req[idx] ? {1'b1, IDW'(idx)} : res;
    end
    return res;
  endfunction

  state_t         r_state,     w_state_nxt;
  logic [IDW-1:0] r_ptr,       w_ptr_nxt;
  logic [N-1:0]   r_gnt,       w_gnt_nxt;
  logic [IDW-1:0] r_owner_id,  w_owner_nxt;
  logic           r_owner_vld, w_owner_vld_nxt;
  logic [7:0]     r_beat_cnt,  w_beat_nxt;
  logic           r_timeout,   w_timeout_nxt;
  logic [2:0]     r_turn_cnt,  w_turn_nxt;
  logic [IDW:0]   w_pick;
  logic           w_arb;
  logic           w_req_own;
  logic           w_last_own;

  assign w_pick     = rr_pick(i_req, r_ptr);
  assign w_req_own  = i_req[r_owner_id];
  assign w_last_own = i_last[r_owner_id];

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_owner_nxt     = r_owner_id;
    w_beat_nxt      = r_beat_cnt;
    w_timeout_nxt   = 1'b0;
    w_turn_nxt      = r_turn_cnt;
    w_arb           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = {N{1'b0}};
        w_arb     = 1'b1;
      end
      ST_OWN: begin
        // abort and normal end share one exit; only a beat-limit exit flags a timeout
        if (!w_req_own || w_last_own) begin
          w_state_nxt = ST_TURN;
          w_gnt_nxt   = {N{1'b0}};
          w_turn_nxt  = 3'd0;
        end else if (r_beat_cnt >= BEAT_MAX) begin
          w_state_nxt   = ST_TURN;
          w_gnt_nxt     = {N{1'b0}};
          w_turn_nxt    = 3'd0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_beat_nxt = r_beat_cnt + 8'd1;
        end
      end
      ST_TURN: begin
        w_gnt_nxt = {N{1'b0}};
        if (r_turn_cnt >= TURN_LAST) begin
          w_state_nxt = ST_IDLE;
          w_arb       = 1'b1;
        end else begin
          w_turn_nxt = r_turn_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = {N{1'b0}};
      end
    endcase

    if (w_arb && w_pick[IDW]) begin
      w_state_nxt = ST_OWN;
      w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick[IDW-1:0];
      w_owner_nxt = w_pick[IDW-1:0];
      w_beat_nxt  = 8'd0;
      w_ptr_nxt   = (w_pick[IDW-1:0] == ID_LAST) ? {IDW{1'b0}}
                                                 : w_pick[IDW-1:0] + IDW'(1'b1);
    end else begin
      w_ptr_nxt = w_ptr_nxt;
    end

    w_owner_vld_nxt = |w_gnt_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= {IDW{1'b0}};
      r_gnt       <= {N{1'b0}};
      r_owner_id  <= {IDW{1'b0}};
      r_owner_vld <= 1'b0;
      r_beat_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
      r_turn_cnt  <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_owner_id  <= w_owner_nxt;
      r_owner_vld <= w_owner_vld_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_timeout   <= w_timeout_nxt;
      r_turn_cnt  <= w_turn_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_owner_id  = r_owner_id;
  assign o_owner_vld = r_owner_vld;
  assign o_beat_cnt  = r_beat_cnt;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Scoreboard bench: two arbiters (turnaround 1 and 3) checked cycle by cycle against
// a transaction-level reference, plus directed scenarios and random traffic.
module tb_shared_net_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req0, last0, req1, last1;
  logic [3:0] gnt0, gnt1;
  logic [1:0] id0, id1;
  logic       vld0, vld1, to0, to1;
  logic [7:0] bc0, bc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shared_net_arbiter #(.N(4), .MAX_BEATS(8), .TURN_CYC(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_last(last0),
    .o_gnt(gnt0), .o_owner_id(id0), .o_owner_vld(vld0), .o_beat_cnt(bc0), .o_timeout(to0));

  shared_net_arbiter #(.N(4), .MAX_BEATS(5), .TURN_CYC(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_last(last1),
    .o_gnt(gnt1), .o_owner_id(id1), .o_owner_vld(vld1), .o_beat_cnt(bc1), .o_timeout(to1));

  typedef struct {int ptr; int owner; bit own; int beats; int gap; bit tmo;} ms_t;
  typedef struct {logic [3:0] gnt; logic [1:0] id; logic vld; logic [7:0] bc; logic tmo;} ex_t;

  ms_t m0, m1;
  ex_t q0[$], q1[$];
  int  ev0_own[$], ev0_gap[$], ev0_len[$], ev1_own[$], ev1_gap[$], ev1_len[$];
  int  tc0, tc1, z0, z1, r0, r1;
  logic [3:0] pg0, pg1;

  // gap counts turnaround cycles still to come; arbitration happens when it is 0 or 1
  function automatic ms_t mstep(ms_t s, logic [3:0] rq, logic [3:0] ls, int tc, int mb);
    ms_t n = s;
    bit  arb = 1'b0;
    bit  found = 1'b0;
    n.tmo = 1'b0;
    if (s.own) begin
      if (!rq[s.owner] || ls[s.owner] || s.beats == mb - 1) begin
        n.own = 1'b0;
        n.gap = tc;
        n.tmo = rq[s.owner] && !ls[s.owner];
      end else n.beats = s.beats + 1;
    end else if (s.gap > 1) n.gap = s.gap - 1;
    else begin
      n.gap = 0;
      arb = 1'b1;
    end
    if (arb) begin
      for (int k = 0; k < 4; k++) begin
        int i = (s.ptr + k) % 4;
        if (!found && rq[i]) begin
          found = 1'b1; n.own = 1'b1; n.owner = i; n.beats = 0; n.ptr = (i + 1) % 4;
        end
      end
    end
    return n;
  endfunction

  function automatic ex_t mexp(ms_t s);
    ex_t e;
    e.gnt = s.own ? 4'(1 << s.owner) : 4'd0;
    e.id  = 2'(s.owner);
    e.vld = s.own;
    e.bc  = 8'(s.beats);
    e.tmo = s.tmo;
    return e;
  endfunction

  function automatic ms_t mzero();
    ms_t z = '{0, 0, 1'b0, 0, 0, 1'b0};
    return z;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(string t, ex_t e, logic [3:0] g, logic [1:0] id, logic v, logic [7:0] bc, logic to);
    chk({t, "_gnt"}, int'(g), int'(e.gnt));
    chk({t, "_owner_id"}, int'(id), int'(e.id));
    chk({t, "_owner_vld"}, int'(v), int'(e.vld));
    chk({t, "_timeout"}, int'(to), int'(e.tmo));
    if (e.vld) chk({t, "_beat_cnt"}, int'(bc), int'(e.bc));
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete();
    m0 = mzero(); m1 = mzero();
    ev0_own.delete(); ev0_gap.delete(); ev0_len.delete();
    ev1_own.delete(); ev1_gap.delete(); ev1_len.delete();
    tc0 = 0; tc1 = 0;
  endtask

  // reference model: advances on every edge with the inputs that edge samples
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        m0 = mstep(m0, req0, last0, 1, 8);
        q0.push_back(mexp(m0));
        m1 = mstep(m1, req1, last1, 3, 5);
        q1.push_back(mexp(m1));
      end
    end
  end

  // monitor: compares on the falling edge and records grant events
  initial begin
    ex_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs0", int'({gnt0, id0, vld0, bc0, to0}), 0);
        chk("reset_outputs3", int'({gnt1, id1, vld1, bc1, to1}), 0);
        pg0 = 4'd0; pg1 = 4'd0; z0 = 0; z1 = 0; r0 = 0; r1 = 0;
      end else begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          cmp("a", e, gnt0, id0, vld0, bc0, to0);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          cmp("b", e, gnt1, id1, vld1, bc1, to1);
        end
        chk("onehot_a", int'($onehot0(gnt0)), 1);
        chk("onehot_b", int'($onehot0(gnt1)), 1);
        if (pg0 != 4'd0 && gnt0 != 4'd0) chk("handover_a", int'(gnt0), int'(pg0));
        if (pg1 != 4'd0 && gnt1 != 4'd0) chk("handover_b", int'(gnt1), int'(pg1));
        if (pg0 == 4'd0 && gnt0 != 4'd0) begin ev0_own.push_back(int'(id0)); ev0_gap.push_back(z0); end
        if (pg1 == 4'd0 && gnt1 != 4'd0) begin ev1_own.push_back(int'(id1)); ev1_gap.push_back(z1); end
        if (pg0 != 4'd0 && gnt0 == 4'd0) ev0_len.push_back(r0);
        if (pg1 != 4'd0 && gnt1 == 4'd0) ev1_len.push_back(r1);
        z0 = (gnt0 == 4'd0) ? z0 + 1 : 0;
        z1 = (gnt1 == 4'd0) ? z1 + 1 : 0;
        r0 = (gnt0 != 4'd0) ? r0 + 1 : 0;
        r1 = (gnt1 != 4'd0) ? r1 + 1 : 0;
        tc0 += int'(to0);
        tc1 += int'(to1);
        pg0 = gnt0; pg1 = gnt1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic idle_inputs();
    req0 = 4'd0; last0 = 4'd0; req1 = 4'd0; last1 = 4'd0;
  endtask

  initial begin
    logic [3:0] mask;
    rst_n = 1'b0;
    idle_inputs();
    clear_all();
    pg0 = 4'd0; pg1 = 4'd0; z0 = 0; z1 = 0; r0 = 0; r1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // single request, last on the third owned cycle
    do_reset();
    req0 = 4'b0001;
    repeat (3) cyc();
    last0 = 4'b0001;
    cyc();
    idle_inputs();
    repeat (4) cyc();
    chk("t1_grants", ev0_own.size(), 1);
    if (ev0_len.size() > 0) chk("t1_own_len", ev0_len[0], 3);

    // round-robin (turnaround 1) and turnaround 3, one-beat ownerships
    do_reset();
    req0 = 4'b1111; last0 = 4'b1111;
    req1 = 4'b0011; last1 = 4'b0011;
    repeat (12) cyc();
    idle_inputs();
    repeat (6) cyc();
    chk("t2_grant_count", int'(ev0_own.size() >= 5), 1);
    if (ev0_own.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), ev0_own[i], i % 4);
      for (int i = 1; i < 5; i++) chk($sformatf("t2_gap%0d", i), ev0_gap[i], 1);
      chk("t2_own_len", ev0_len[0], 1);
    end
    chk("t5_grant_count", int'(ev1_own.size() >= 2), 1);
    if (ev1_own.size() >= 2) begin
      chk("t5_first", ev1_own[0], 0);
      chk("t5_second", ev1_own[1], 1);
      chk("t5_gap", ev1_gap[1], 3);
    end

    // timeout and re-grant of the same requester
    do_reset();
    req0 = 4'b0100;
    repeat (12) cyc();
    idle_inputs();
    repeat (4) cyc();
    chk("t3_timeouts", tc0, 1);
    chk("t3_grant_count", int'(ev0_own.size() >= 2), 1);
    if (ev0_own.size() >= 2) begin
      chk("t3_first", ev0_own[0], 2);
      chk("t3_second", ev0_own[1], 2);
      chk("t3_gap", ev0_gap[1], 1);
      chk("t3_own_len", ev0_len[0], 8);
    end

    // abort wins over last; another requester arrives in the same cycle
    do_reset();
    req0 = 4'b0010;
    repeat (2) cyc();
    req0 = 4'b1000; last0 = 4'b0010;
    cyc();
    last0 = 4'b0000;
    repeat (4) cyc();
    idle_inputs();
    repeat (4) cyc();
    chk("t4_timeouts", tc0, 0);
    chk("t4_grant_count", int'(ev0_own.size() >= 2), 1);
    if (ev0_own.size() >= 2) begin
      chk("t4_first", ev0_own[0], 1);
      chk("t4_second", ev0_own[1], 3);
      chk("t4_gap", ev0_gap[1], 1);
      chk("t4_own_len", ev0_len[0], 2);
    end

    // asynchronous reset in the middle of an ownership
    do_reset();
    req0 = 4'b0010;
    repeat (5) cyc();
    chk("t6_pre_gnt", int'(gnt0), 2);
    chk("t6_pre_beat", int'(bc0), 4);
    #1;
    rst_n = 1'b0;
    clear_all();
    #1;
    chk("t6_async_clear", int'({gnt0, id0, vld0, bc0, to0}), 0);
    req0 = 4'b0110;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc();
    idle_inputs();
    repeat (4) cyc();
    chk("t6_grant_count", int'(ev0_own.size() >= 1), 1);
    if (ev0_own.size() >= 1) chk("t6_first_after_reset", ev0_own[0], 1);

    // random traffic with occasional asynchronous resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) mask[i] = ($urandom_range(0, 7) == 0);
      req0 = req0 ^ mask;
      for (int i = 0; i < 4; i++) mask[i] = ($urandom_range(0, 7) == 0);
      req1 = req1 ^ mask;
      for (int i = 0; i < 4; i++) last0[i] = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 4; i++) last1[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else cyc();
    end
    idle_inputs();
    repeat (12) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_net_arbiter.md
# shared_net_arbiter

Round-robin arbiter that shares one multi-driven (wired/tri-state) net among N requesters, so that at most one driver is enabled at any time. It enforces a bus turnaround gap with no driver enabled between owners, and bounds ownership with a beat timeout. It sits in front of the tri-state driver enables of a shared `triand`/`tri0` net and issues one-hot driver enables plus owner status.

## Interface
- `N`, 4: number of requesters, 2..8.
- `MAX_BEATS`, 8: maximum ownership length in cycles, 2..255.
- `TURN_CYC`, 1: idle cycles with no driver enabled between owners, 1..7.
- `clk`  input  1  rising-edge clock; the block's only clock.
- `rst_n`  input  1  reset; asynchronous and active-low.
- `req`  input  N  per-requester request level; held high until granted and for the whole transfer.
- `last`  input  N  per-requester final-beat strobe; sampled only for the current owner.
- `gnt`  output  N  one-hot driver enable; all-zero when no owner.
- `owner_id`  output  $clog2(N)  index of the current owner; holds the last owner when none.
- `owner_vld`  output  1  equals `|gnt`.
- `beat_cnt`  output  8  beats elapsed in the current ownership, starting at 0 on the grant cycle.
- `timeout`  output  1  one-cycle pulse on forced release.

## Operation
- FSM states: IDLE, OWN, TURN. All outputs are registered.
- IDLE
  - `gnt` = 0.
  - If `req` != 0, the winner is the first set bit scanning upward from `ptr`, wrapping modulo N.
  - Next cycle: state OWN, `gnt[winner]` = 1, `owner_id` = winner, `beat_cnt` = 0.
  - `ptr` ← (winner+1) mod N, updated on each grant.
- OWN
  - `beat_cnt` increments by 1 each cycle.
  - Exit to TURN on the first of these conditions, with priority in this order:
    - (a) `req[owner]` = 0: abort, no error.
    - (b) `last[owner]` = 1: normal end.
    - (c) `beat_cnt` = MAX_BEATS-1 and none of the above: forced release, `timeout` = 1 in the first TURN cycle.
  - `gnt` goes to 0 in the first TURN cycle.
  - `last`/`req` of non-owners are ignored.
- TURN
  - Lasts exactly TURN_CYC cycles with `gnt` = 0.
  - `req` is sampled in the last TURN cycle. If nonzero, the arbitration above runs and the new owner's `gnt` rises the following cycle. Otherwise the state goes to IDLE.
  - The just-released owner can win again only if no other requester is pending, because `ptr` has already passed it.
- `gnt` is never more than one-hot, and is never nonzero in two consecutive cycles for different owners.
- `beat_cnt` is 8 bits and saturates at MAX_BEATS-1; it does not wrap.
- Reset (asynchronous, at any point including mid-ownership): state = IDLE, `gnt` = 0, `owner_vld` = 0, `owner_id` = 0, `beat_cnt` = 0, `timeout` = 0, `ptr` = 0. The outputs clear immediately, without waiting for a clock edge.

## Timing
- Grant latency from IDLE: `req` sampled high at edge k → `gnt` high after edge k (first OWN cycle).
- Release: the exit condition is sampled at edge k → `gnt` low after edge k. The next owner's `gnt` rises after edge k+TURN_CYC.
- Minimum ownership is 1 cycle: `last` high in the first OWN cycle.
- Maximum ownership is MAX_BEATS cycles.
- Back-to-back throughput with all requesters busy: one ownership per (ownership length + TURN_CYC) cycles.
- `timeout` is high for exactly one cycle, coincident with the first TURN cycle.
- `req`/`last` are treated as synchronous to `clk`.

## Test plan
- Single request, default parameters (N=4, TURN_CYC=1): `req`=0001 in IDLE, `last[0]` on the 3rd OWN cycle → `gnt`=0001 for 3 cycles (`beat_cnt` 0,1,2), then 1 cycle of `gnt`=0000, then IDLE.
- Round-robin fairness: `req`=1111 held, each owner asserts `last` on its 1st beat → grant order 0,1,2,3,0, each grant separated by exactly 1 zero cycle; `ptr` wraps from 3 to 0.
- Timeout: `req`=0100, `last` never asserted, MAX_BEATS=8 → `gnt`=0100 for 8 cycles (`beat_cnt` 0..7), `timeout` pulses once with `gnt`=0000, then requester 2 is re-granted after TURN.
- Abort plus simultaneous events: owner 1 drops `req[1]` in the same cycle `last[1]`=1 and `req[3]` rises → abort path taken, `timeout`=0, TURN, then `gnt`=1000.
- Turnaround length: TURN_CYC=3 with `req`=0011 → exactly 3 cycles of `gnt`=0000 between owner 0 and owner 1; a monitor checks that `gnt` is never 2-hot across the whole test.
- Reset mid-ownership: assert `rst_n`=0 asynchronously while `gnt`=0010, `beat_cnt`=4 → all outputs 0 before the next edge. After release with `req`=0110, the first grant is to requester 1, confirming `ptr` was reset to 0.
